lsm_sequencer: RTL and testbench

- Control-side counterpart of the load/store-multiple register-list manager.
- Decodes an LDM/STM instruction word and walks its 16-bit register list lowest register first.
- For each listed register, issues one word memory transfer with an MFC (memory function complete) handshake, and drives register-file write enables for loads.
- Produces the base-register writeback value; sits between the control unit and the memory/register-file datapath.

---
 rtl/lsm_pkg.sv | 23 ++
 rtl/lsm_if.sv | 42 ++++
 rtl/lsm_priority_enc.sv | 20 ++
 rtl/lsm_sequencer.sv | 162 ++++++++++++++++
 tb/tb_lsm_sequencer.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/lsm_pkg.sv
// Shared definitions for the load/store-multiple sequencer: FSM encoding,
// instruction field positions and the transfer word size.
package lsm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_REQ,
      ST_WB,
      ST_DONE
   } lsm_state_t;

   localparam int IR_P_BIT    = 24;
   localparam int IR_U_BIT    = 23;
   localparam int IR_W_BIT    = 21;
   localparam int IR_L_BIT    = 20;
   localparam int IR_RN_MSB   = 19;
   localparam int IR_RN_LSB   = 16;
   localparam int IR_LIST_MSB = 15;
   localparam int LIST_W      = 16;
   localparam int WORD_BYTES  = 4;

endpackage

// File: rtl/lsm_if.sv
// Control/memory/register-file signal bundle of the LDM/STM sequencer.
// ABORT exists only when LSM_MFC_TIMEOUT_EN is defined.
interface lsm_if #(parameter int ADDR_W = 32);

   logic              START;
   logic [31:0]       IR;
   logic [ADDR_W-1:0] BASE;
   logic              MFC;
   logic              BUSY;
   logic              MEM_REQ;
   logic              MEM_RW;
   logic [ADDR_W-1:0] MEM_ADDR;
   logic [3:0]        REG_NUM;
   logic              REG_WE;
   logic              WB_EN;
   logic [ADDR_W-1:0] WB_VALUE;
   logic [4:0]        LSM_COUNTER;
   logic              DONE;
`ifdef LSM_MFC_TIMEOUT_EN
   logic              ABORT;
`endif

   // The sequencer drives the memory request side, hence it is the master.
   modport master (
      input  START, IR, BASE, MFC,
      output BUSY, MEM_REQ, MEM_RW, MEM_ADDR, REG_NUM, REG_WE,
             WB_EN, WB_VALUE, LSM_COUNTER, DONE
`ifdef LSM_MFC_TIMEOUT_EN
      , output ABORT
`endif
   );

   modport slave (
      output START, IR, BASE, MFC,
      input  BUSY, MEM_REQ, MEM_RW, MEM_ADDR, REG_NUM, REG_WE,
             WB_EN, WB_VALUE, LSM_COUNTER, DONE
`ifdef LSM_MFC_TIMEOUT_EN
      , input ABORT
`endif
   );

endinterface

// File: rtl/lsm_priority_enc.sv
// Lowest-set-bit encoder for the 16-bit register-list mask.
module lsm_priority_enc (
   input  logic [15:0] mask,
   output logic [3:0]  idx,
   output logic        valid
);

   // Scan high to low so the lowest set bit is the last one to win.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = 15; i >= 0; i--) begin
         if (mask[i]) begin
            idx   = 4'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/lsm_sequencer.sv
// LDM/STM sequencer: walks the register list lowest first, one MFC-handshaked
// word transfer per register. Optional MFC timeout: LSM_MFC_TIMEOUT_EN.
module lsm_sequencer
   import lsm_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic CLK,
   input  logic RESET,
   lsm_if.master bus
);

   lsm_state_t        state_q, state_d;
   logic              p_q, u_q, w_q, l_q;
   logic [3:0]        rn_q;
   logic [LIST_W-1:0] list_q, mask_q, mask_next;
   logic [ADDR_W-1:0] base_q, addr_q, wb_value_q;
   logic [ADDR_W-1:0] four_n, start_addr;
   logic [4:0]        cnt_q, n_setup;
   logic [3:0]        enc_idx;
   logic              enc_valid;
   logic              xfer;
   logic              timeout_hit;
   logic              unused_ir;

   localparam logic [ADDR_W-1:0] WORD = ADDR_W'(WORD_BYTES);

   assign unused_ir = ^{bus.IR[31:IR_P_BIT+1], bus.IR[IR_U_BIT-1]};

   lsm_priority_enc u_enc (
      .mask  (mask_q),
      .idx   (enc_idx),
      .valid (enc_valid)
   );

   assign xfer      = (state_q == ST_REQ) && bus.MFC;
   assign mask_next = mask_q & (mask_q - LIST_W'(1));

   always_comb begin
      n_setup = '0;
      for (int i = 0; i < LIST_W; i++) begin
         n_setup = n_setup + 5'(list_q[i]);
      end
   end

   assign four_n = ADDR_W'({n_setup, 2'b00});

   // Lowest address of the block; descending modes still walk upward.
   always_comb begin
      unique case ({p_q, u_q})
         2'b01:   start_addr = base_q;
         2'b11:   start_addr = base_q + WORD;
         2'b00:   start_addr = base_q - four_n + WORD;
         default: start_addr = base_q - four_n;
      endcase
   end

`ifdef LSM_MFC_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] to_cnt_q;
   logic            abort_q;

   assign timeout_hit = (state_q == ST_REQ) && !bus.MFC &&
                        (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         to_cnt_q <= '0;
         abort_q  <= 1'b0;
      end else begin
         if ((state_q == ST_REQ) && !bus.MFC) to_cnt_q <= to_cnt_q + TO_W'(1);
         else                                 to_cnt_q <= '0;
         abort_q <= timeout_hit;
      end
   end

   assign bus.ABORT = abort_q;
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;

   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (bus.START) state_d = ST_SETUP;
         ST_SETUP: state_d = (n_setup != 5'd0) ? ST_REQ : ST_DONE;
         ST_REQ: begin
            if (!enc_valid)               state_d = ST_DONE;
            else if (bus.MFC) begin
               if (mask_next != '0)       state_d = ST_REQ;
               else if (w_q)              state_d = ST_WB;
               else                       state_d = ST_DONE;
            end else if (timeout_hit)     state_d = ST_DONE;
         end
         ST_WB:    state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.BUSY    = (state_q != ST_IDLE);
      bus.MEM_REQ = (state_q == ST_REQ);
      bus.REG_WE  = xfer && l_q;
      // A loaded Rn overrides the writeback value.
      bus.WB_EN   = (state_q == ST_WB) && !(l_q && list_q[rn_q]);
      bus.DONE    = (state_q == ST_DONE);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         p_q        <= 1'b0;
         u_q        <= 1'b0;
         w_q        <= 1'b0;
         l_q        <= 1'b0;
         rn_q       <= '0;
         list_q     <= '0;
         base_q     <= '0;
         mask_q     <= '0;
         addr_q     <= '0;
         wb_value_q <= '0;
         cnt_q      <= '0;
      end else begin
         if ((state_q == ST_IDLE) && bus.START) begin
            p_q    <= bus.IR[IR_P_BIT];
            u_q    <= bus.IR[IR_U_BIT];
            w_q    <= bus.IR[IR_W_BIT];
            l_q    <= bus.IR[IR_L_BIT];
            rn_q   <= bus.IR[IR_RN_MSB:IR_RN_LSB];
            list_q <= bus.IR[IR_LIST_MSB:0];
            base_q <= bus.BASE;
         end
         if (state_q == ST_SETUP) begin
            mask_q     <= list_q;
            cnt_q      <= n_setup;
            addr_q     <= start_addr;
            wb_value_q <= u_q ? (base_q + four_n) : (base_q - four_n);
         end
         if (xfer) begin
            mask_q <= mask_next;
            addr_q <= addr_q + WORD;
            cnt_q  <= cnt_q - 5'd1;
         end
      end
   end

   assign bus.MEM_RW      = l_q;
   assign bus.MEM_ADDR    = addr_q;
   assign bus.REG_NUM     = enc_idx;
   assign bus.WB_VALUE    = wb_value_q;
   assign bus.LSM_COUNTER = cnt_q;

endmodule

// File: tb/tb_lsm_sequencer.sv
// Self-checking bench for lsm_sequencer: directed and random LDM/STM operations
// against a list/arithmetic reference model. Define LSM_MFC_TIMEOUT_EN to cover ABORT.
module tb_lsm_sequencer;

   localparam int ADDR_W = 32;
   localparam int TO_CYC = 16;

   logic CLK = 1'b0;
   logic RESET;

   always #5 CLK = ~CLK;

   lsm_if #(.ADDR_W(ADDR_W)) bus ();

   lsm_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO_CYC)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".busy"},  bus.BUSY, 0);
      chk({tag, ".req"},   bus.MEM_REQ, 0);
      chk({tag, ".rw"},    bus.MEM_RW, 0);
      chk({tag, ".we"},    bus.REG_WE, 0);
      chk({tag, ".wben"},  bus.WB_EN, 0);
      chk({tag, ".done"},  bus.DONE, 0);
      chk({tag, ".addr"},  bus.MEM_ADDR, 0);
      chk({tag, ".reg"},   bus.REG_NUM, 0);
      chk({tag, ".wbval"}, bus.WB_VALUE, 0);
      chk({tag, ".cnt"},   bus.LSM_COUNTER, 0);
   endtask

   // One LDM/STM operation. d = REQ cycles waited before MFC per transfer;
   // rst_after > 0 resets right after that many MFCs; start_at_done pulses
   // START during the DONE cycle, which must be ignored.
   task automatic run_op(input string tag, input logic [31:0] ir, input logic [31:0] base,
                         input int d, input int rst_after, input bit start_at_done);
      logic [15:0] list;
      logic [31:0] lowest, wbv;
      logic [31:0] exp_addr[$];
      int          exp_reg[$];
      int          n, k, w, exp_done;
      bit          is_u, is_p, is_w, is_l, exp_wb, ab, exp_req;

      list = ir[15:0];
      is_p = ir[24]; is_u = ir[23]; is_w = ir[21]; is_l = ir[20];
      n    = $countones(list);
      // Block occupies 4n bytes above (U=1) or below (U=0) BASE; P shifts it by a word.
      if (is_u) lowest = base + (is_p ? 32'd4 : 32'd0);
      else      lowest = base - 32'(4 * n) + (is_p ? 32'd0 : 32'd4);
      wbv = is_u ? base + 32'(4 * n) : base - 32'(4 * n);
      for (int r = 0; r < 16; r++) begin
         if (list[r]) begin
            exp_addr.push_back(lowest + 32'(4 * exp_reg.size()));
            exp_reg.push_back(r);
         end
      end
      ab = 1'b0;
`ifdef LSM_MFC_TIMEOUT_EN
      ab = (n > 0) && (d >= TO_CYC);
`endif
      exp_wb   = is_w && (n > 0) && !ab && !(is_l && list[ir[19:16]]);
      exp_done = ab ? 2 + TO_CYC : 2 + n * (d + 1) + ((is_w && n > 0) ? 1 : 0);

      @(negedge CLK);
      bus.START = 1'b1; bus.IR = ir; bus.BASE = base; bus.MFC = 1'b0;
      @(negedge CLK);
      bus.START = 1'b0; bus.IR = $urandom; bus.BASE = $urandom;
      k = 0; w = 0;
      for (int cyc = 1; cyc <= exp_done; cyc++) begin
         exp_req = (cyc >= 2) && (k < n) && (cyc < exp_done);
         chk({tag, ".mem_req"}, bus.MEM_REQ, exp_req);
         chk({tag, ".busy"}, bus.BUSY, 1);
         if (exp_req) begin
            if (w == 0) begin
               chk({tag, ".addr"}, bus.MEM_ADDR, exp_addr[k]);
               chk({tag, ".reg_num"}, bus.REG_NUM, exp_reg[k]);
               chk({tag, ".counter"}, bus.LSM_COUNTER, n - k);
               chk({tag, ".mem_rw"}, bus.MEM_RW, is_l);
            end
            bus.MFC = (w == d);
         end else begin
            bus.MFC = 1'($urandom_range(0, 1));
         end
         #1;
         chk({tag, ".reg_we"}, bus.REG_WE, exp_req && bus.MFC && is_l);
         if (exp_req) begin
            if (bus.MFC) begin
               k++; w = 0;
               if (rst_after > 0 && k == rst_after) begin
                  RESET = 1'b1;
                  #1;
                  chk_all_zero({tag, ".rst_mid"});
                  bus.MFC = 1'b0;
                  @(negedge CLK);
                  RESET = 1'b0;
                  repeat (3) begin
                     @(negedge CLK);
                     chk({tag, ".post_rst_wben"}, bus.WB_EN, 0);
                     chk({tag, ".post_rst_busy"}, bus.BUSY, 0);
                  end
                  return;
               end
            end else begin
               w++;
            end
         end
         chk({tag, ".done"}, bus.DONE, cyc == exp_done);
         chk({tag, ".wb_en"}, bus.WB_EN, exp_wb && (cyc == exp_done - 1));
         if (exp_wb && cyc == exp_done - 1) chk({tag, ".wb_value"}, bus.WB_VALUE, wbv);
         if (cyc == exp_done) begin
            if (!ab) chk({tag, ".final_counter"}, bus.LSM_COUNTER, 0);
`ifdef LSM_MFC_TIMEOUT_EN
            chk({tag, ".abort"}, bus.ABORT, ab);
`endif
            if (start_at_done) begin
               bus.START = 1'b1;
               bus.IR    = 32'h00A0_0000 | 32'($urandom_range(1, 16'hFFFF));
            end
         end else begin
            @(negedge CLK);
         end
      end
      chk({tag, ".xfers"}, k, ab ? 0 : n);
      @(negedge CLK);
      bus.START = 1'b0;
      bus.MFC   = 1'b0;
      chk({tag, ".busy_after"}, bus.BUSY, 0);
      @(negedge CLK);
      chk({tag, ".idle_after"}, bus.BUSY, 0);
      chk({tag, ".req_after"}, bus.MEM_REQ, 0);
   endtask

   initial begin
      logic [31:0] ir, base;
      RESET = 1'b1;
      bus.START = 1'b0; bus.IR = '0; bus.BASE = '0; bus.MFC = 1'b0;
      repeat (2) @(negedge CLK);
      chk_all_zero("reset");
`ifdef LSM_MFC_TIMEOUT_EN
      chk("reset.abort", bus.ABORT, 0);
`endif
      RESET = 1'b0;

      // STM IA with writeback, four registers.
      run_op("stm_ia", 32'h00A1_000F, 32'h0000_0100, 1, 0, 1'b0);
      // LDM DB without writeback, registers 0 and 15.
      run_op("ldm_db", 32'h0113_8001, 32'h0000_0200, 1, 0, 1'b0);
      // LDM IA, Rn in the list: loaded value wins over writeback.
      run_op("ldm_rn", 32'h00B2_0004, 32'h0000_0040, 0, 0, 1'b0);
      // Empty list, with START coincident with DONE.
      run_op("empty", 32'h00A0_0000, 32'h0000_0300, 0, 0, 1'b1);
      // STM DA with writeback.
      run_op("stm_da", 32'h0025_0A50, 32'h0000_1000, 2, 0, 1'b0);
      // Address wrap past the top of the address space.
      run_op("wrap", 32'h01B4_00FF, 32'hFFFF_FFF0, 0, 0, 1'b0);
      // Full list, slow memory, reset after the fifth MFC.
      run_op("full_rst", 32'h00B0_FFFF, 32'h0000_2000, 3, 5, 1'b0);
      // Full list to completion.
      run_op("full", 32'h01A0_FFFF, 32'h0000_4000, 0, 0, 1'b1);

      for (int t = 0; t < 10; t++) begin
         ir   = $urandom;
         ir[15:0] = 16'($urandom & $urandom);
         base = $urandom & 32'hFFFF_FFFC;
         run_op($sformatf("rand%0d", t), ir, base, $urandom_range(0, 3), 0, 1'($urandom_range(0, 1)));
      end

`ifdef LSM_MFC_TIMEOUT_EN
      // MFC never arrives: ABORT with DONE, no writeback.
      run_op("timeout", 32'h00A1_0006, 32'h0000_0800, 1000, 0, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
